// File: rtl/theta_apply_stream.sv
// theta_apply_stream
// Word-serial theta mixing stage. Accepts the five column-parity words in one
// transfer, derives the five mixing words D[x] = C[x-1] ^ rotl(C[x+1], ROT_AMT)
// (indices mod 5), then passes the block of 5*WORDS_PER_COL state words
// through, XORing each word with D of its column. The output side holds a
// single word.
//
// Ports
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_c_valid / o_c_ready       parity vector handshake (ready only in IDLE)
//   i_c[32k+31:32k]             parity word C[k], k = 0..4 (k = 4 is C_5)
//   i_word_valid / o_word_ready input state word handshake
//   i_word                      input state word, column-major order
//   o_word_valid / i_word_ready output word handshake
//   o_word                      i_word ^ D[column]
//   o_word_last                 high while the held word is the final one
//   o_busy                      high in COMPUTE and STREAM
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a parity vector; C latched on i_c_valid
// S_COMPUTE | one cycle: D[0..4] registered from latched C, counters cleared
// S_STREAM  | words flow through; leaves after the last output is accepted

module theta_apply_stream #(
   parameter int ROT_AMT       = 1,
   parameter int WORDS_PER_COL = 5
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_c_valid,
   output logic         o_c_ready,
   input  logic [159:0] i_c,
   input  logic         i_word_valid,
   output logic         o_word_ready,
   input  logic [31:0]  i_word,
   output logic         o_word_valid,
   input  logic         i_word_ready,
   output logic [31:0]  o_word,
   output logic         o_word_last,
   output logic         o_busy
);

   localparam int NWORDS = 5 * WORDS_PER_COL;
   localparam int CNT_W  = $clog2(NWORDS + 1);
   localparam int ROW_W  = (WORDS_PER_COL > 1) ? $clog2(WORDS_PER_COL) : 1;
   localparam int ROT    = ROT_AMT % 32;

   localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(NWORDS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NWORDS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(WORDS_PER_COL - 1);
   localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_STREAM  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       c_q [5];
   logic [31:0]       c_d [5];
   logic [31:0]       d_q [5];
   logic [31:0]       d_d [5];
   logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
   logic [2:0]        in_col_q, in_col_d;
   logic [ROW_W-1:0]  in_row_q, in_row_d;
   logic [31:0]       word_q, word_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic              word_ready;
   logic              load;
   logic              accept;

   // Rotation done on a doubled word so ROT = 0 degenerates cleanly.
   function automatic logic [31:0] rotl32(input logic [31:0] v);
      logic [63:0] dbl;
      dbl = {v, v} << ROT;
      return dbl[63:32];
   endfunction

   always_comb begin
      state_d    = state_q;
      c_d        = c_q;
      d_d        = d_q;
      in_cnt_d   = in_cnt_q;
      out_cnt_d  = out_cnt_q;
      in_col_d   = in_col_q;
      in_row_d   = in_row_q;
      word_d     = word_q;
      valid_d    = valid_q;
      last_d     = last_q;
      word_ready = 1'b0;
      load       = 1'b0;
      accept     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_c_valid) begin
               for (int k = 0; k < 5; k++) begin
                  c_d[k] = i_c[32*k +: 32];
               end
               state_d = S_COMPUTE;
            end
         end

         S_COMPUTE: begin
            d_d[0]    = c_q[4] ^ rotl32(c_q[1]);
            d_d[1]    = c_q[0] ^ rotl32(c_q[2]);
            d_d[2]    = c_q[1] ^ rotl32(c_q[3]);
            d_d[3]    = c_q[2] ^ rotl32(c_q[4]);
            d_d[4]    = c_q[3] ^ rotl32(c_q[0]);
            in_cnt_d  = '0;
            out_cnt_d = '0;
            in_col_d  = '0;
            in_row_d  = '0;
            valid_d   = 1'b0;
            last_d    = 1'b0;
            state_d   = S_STREAM;
         end

         S_STREAM: begin
            word_ready = (in_cnt_q < CNT_END) && (!valid_q || i_word_ready);
            load       = word_ready && i_word_valid;
            accept     = valid_q && i_word_ready;

            if (accept) begin
               out_cnt_d = out_cnt_q + CNT_ONE;
               valid_d   = 1'b0;
               last_d    = 1'b0;
               if (out_cnt_q == CNT_LAST) begin
                  state_d = S_IDLE;
               end
            end

            // A load on the same edge as an accept overrides the clear above,
            // so the slot refills without a bubble.
            if (load) begin
               word_d   = i_word ^ d_q[in_col_q];
               valid_d  = 1'b1;
               last_d   = (in_cnt_q == CNT_LAST);
               in_cnt_d = in_cnt_q + CNT_ONE;
               if (in_row_q == ROW_LAST) begin
                  in_row_d = '0;
                  in_col_d = in_col_q + 3'd1;
               end else begin
                  in_row_d = in_row_q + ROW_ONE;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         for (int k = 0; k < 5; k++) begin
            c_q[k] <= '0;
            d_q[k] <= '0;
         end
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         in_col_q  <= '0;
         in_row_q  <= '0;
         word_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         c_q       <= c_d;
         d_q       <= d_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         in_col_q  <= in_col_d;
         in_row_q  <= in_row_d;
         word_q    <= word_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
      end
   end

   assign o_c_ready    = (state_q == S_IDLE);
   assign o_word_ready = word_ready;
   assign o_word_valid = valid_q;
   assign o_word       = word_q;
   assign o_word_last  = last_q;
   assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_theta_apply_stream.sv
module tb_theta_apply_stream;

   logic         i_clk;
   logic         i_rst_n;
   logic         i_c_valid;
   logic         o_c_ready;
   logic [159:0] i_c;
   logic         i_word_valid;
   logic         o_word_ready;
   logic [31:0]  i_word;
   logic         o_word_valid;
   logic         i_word_ready;
   logic [31:0]  o_word;
   logic         o_word_last;
   logic         o_busy;

   int vectors;
   int miscompares;
   int span;

   logic [31:0] din_a  [25];
   logic [31:0] dexp_a [5];
   logic [31:0] exp_a  [25];

   theta_apply_stream #(.ROT_AMT(1), .WORDS_PER_COL(5)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_c_valid    (i_c_valid),
      .o_c_ready    (o_c_ready),
      .i_c          (i_c),
      .i_word_valid (i_word_valid),
      .o_word_ready (o_word_ready),
      .i_word       (i_word),
      .o_word_valid (o_word_valid),
      .i_word_ready (i_word_ready),
      .o_word       (o_word),
      .o_word_last  (o_word_last),
      .o_busy       (o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_word"},   o_word,              32'h0);
      chk({tag, "_valid"},  {31'b0, o_word_valid}, 32'h0);
      chk({tag, "_last"},   {31'b0, o_word_last},  32'h0);
      chk({tag, "_busy"},   {31'b0, o_busy},       32'h0);
      chk({tag, "_wready"}, {31'b0, o_word_ready}, 32'h0);
      chk({tag, "_cready"}, {31'b0, o_c_ready},    32'h1);
   endtask

   task automatic load_c(input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2,
                         input logic [31:0] c3, input logic [31:0] c4);
      @(negedge i_clk);
      i_c       = {c4, c3, c2, c1, c0};
      i_c_valid = 1'b1;
      #1;
      chk("load_cready", {31'b0, o_c_ready}, 32'h1);
      @(negedge i_clk);
      i_c_valid = 1'b0;
      #1;
      chk("compute_busy",   {31'b0, o_busy},       32'h1);
      chk("compute_cready", {31'b0, o_c_ready},    32'h0);
      chk("compute_wready", {31'b0, o_word_ready}, 32'h0);
   endtask

   task automatic build_expected();
      for (int k = 0; k < 25; k++) exp_a[k] = din_a[k] ^ dexp_a[k / 5];
   endtask

   // Drives one block. stall_at >= 0: ready held low 10 cycles once that word
   // is loaded. abort_at > 0: stop after that many output handshakes.
   task automatic run_block(input int stall_at, input int abort_at, input bit c_pulse,
                            output int out_span);
      int in_idx = 0, out_idx = 0, cyc = 0, first_cyc = -1, last_cyc = -1, stall = 0;
      bit stall_done = 0, pulsed = 0;
      build_expected();
      while (out_idx < 25 && cyc < 300 && !(abort_at > 0 && out_idx >= abort_at)) begin
         @(negedge i_clk);
         i_c_valid = 1'b0;
         if (stall_at >= 0 && !stall_done && in_idx == stall_at + 1) begin
            stall      = 10;
            stall_done = 1;
         end
         i_word_ready = (stall == 0);
         i_word_valid = (in_idx < 25);
         i_word       = (in_idx < 25) ? din_a[in_idx] : 32'h0;
         if (c_pulse && !pulsed && in_idx == 5) begin
            i_c       = {128'h0, 32'hDEADBEEF};
            i_c_valid = 1'b1;
            pulsed    = 1;
         end
         #1;
         if (i_c_valid) chk("pulse_cready", {31'b0, o_c_ready}, 32'h0);
         if (stall > 0) begin
            chk("stall_word",   o_word,                exp_a[stall_at]);
            chk("stall_valid",  {31'b0, o_word_valid}, 32'h1);
            chk("stall_wready", {31'b0, o_word_ready}, 32'h0);
            stall--;
         end
         if (o_word_valid && i_word_ready) begin
            chk("out_word", o_word, exp_a[out_idx]);
            chk("out_last", {31'b0, o_word_last}, {31'b0, out_idx == 24});
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            out_idx++;
         end
         if (i_word_valid && o_word_ready) in_idx++;
         cyc++;
      end
      out_span = last_cyc - first_cyc;
      if (abort_at == 0) begin
         chk("out_count", out_idx, 25);
         @(negedge i_clk);
         i_word_valid = 1'b0;
         i_c_valid    = 1'b0;
         #1;
         chk("done_cready", {31'b0, o_c_ready},    32'h1);
         chk("done_busy",   {31'b0, o_busy},       32'h0);
         chk("done_valid",  {31'b0, o_word_valid}, 32'h0);
      end
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      i_rst_n      = 1'b0;
      i_c_valid    = 1'b0;
      i_c          = '0;
      i_word_valid = 1'b0;
      i_word       = '0;
      i_word_ready = 1'b1;
      #12;
      chk_reset_outputs("reset");
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // Idle ignores state words
      @(negedge i_clk);
      i_word_valid = 1'b1;
      #1;
      chk("idle_wready", {31'b0, o_word_ready}, 32'h0);
      @(negedge i_clk);
      #1;
      chk("idle_novalid", {31'b0, o_word_valid}, 32'h0);
      i_word_valid = 1'b0;

      // 1: zero parity, identity pass-through, back-to-back outputs
      for (int k = 0; k < 25; k++) din_a[k] = k;
      for (int x = 0; x < 5; x++) dexp_a[x] = 32'h0;
      load_c(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      run_block(-1, 0, 0, span);
      chk("t1_span", span, 24);

      // 2: C[1]=1 -> D0=2, D2=1
      for (int k = 0; k < 25; k++) din_a[k] = 32'hFFFFFFFF;
      dexp_a[0] = 32'h2; dexp_a[1] = 32'h0; dexp_a[2] = 32'h1; dexp_a[3] = 32'h0; dexp_a[4] = 32'h0;
      load_c(32'h0, 32'h1, 32'h0, 32'h0, 32'h0);
      run_block(-1, 0, 0, span);

      // 3: C_5=0x80000000 -> D0=0x80000000, D3=1 (rotate wrap)
      for (int k = 0; k < 25; k++) din_a[k] = 32'h0;
      dexp_a[0] = 32'h80000000; dexp_a[1] = 32'h0; dexp_a[2] = 32'h0; dexp_a[3] = 32'h1; dexp_a[4] = 32'h0;
      load_c(32'h0, 32'h0, 32'h0, 32'h0, 32'h80000000);
      run_block(-1, 0, 0, span);

      // 4: backpressure after word 3; C = 1,2,4,8,0x10
      for (int k = 0; k < 25; k++) din_a[k] = 32'h100 + k;
      dexp_a[0] = 32'h14; dexp_a[1] = 32'h9; dexp_a[2] = 32'h12; dexp_a[3] = 32'h24; dexp_a[4] = 32'hA;
      load_c(32'h1, 32'h2, 32'h4, 32'h8, 32'h10);
      run_block(3, 0, 0, span);

      // 5: reset after 12 output handshakes, then a clean block
      load_c(32'h1, 32'h2, 32'h4, 32'h8, 32'h10);
      run_block(-1, 12, 0, span);
      @(negedge i_clk);
      i_rst_n      = 1'b0;
      i_word_valid = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      @(negedge i_clk);
      i_rst_n = 1'b1;
      for (int k = 0; k < 25; k++) din_a[k] = 32'h0;
      dexp_a[0] = 32'h80000000; dexp_a[1] = 32'h0; dexp_a[2] = 32'h0; dexp_a[3] = 32'h1; dexp_a[4] = 32'h0;
      load_c(32'h0, 32'h0, 32'h0, 32'h0, 32'h80000000);
      run_block(-1, 0, 0, span);

      // 6: i_c_valid pulse mid-stream is ignored
      for (int k = 0; k < 25; k++) din_a[k] = 32'hFFFFFFFF;
      dexp_a[0] = 32'h2; dexp_a[1] = 32'h0; dexp_a[2] = 32'h1; dexp_a[3] = 32'h0; dexp_a[4] = 32'h0;
      load_c(32'h0, 32'h1, 32'h0, 32'h0, 32'h0);
      run_block(-1, 0, 1, span);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/theta_apply_stream.md
Name: theta_apply_stream

Overview:
- Word-serial consumer of the column-parity vectors C[0:3]/C_5 produced by the parity-reduction stage.
- Latches the five 32-bit parity words and forms the five mixing words D[x] = C[(x+4)%5] ^ rotl(C[(x+1)%5], ROT_AMT).
- Then streams the 25-word state (5 columns x 5 words) through itself, XORing each word with D of its column.
- Sits between the parity stage and the round-permutation datapath; valid/ready on both stream sides.

Parameters:
- ROT_AMT, 1, left-rotate amount applied to C[(x+1)%5]; legal range 0..31.
- WORDS_PER_COL, 5, words per column; block length = 5*WORDS_PER_COL.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_c_valid  in  1  parity vector valid
- o_c_ready  out  1  parity vector accepted (high only in IDLE)
- i_c  in  5x32  parity words; [0..3] = C[0..3], [4] = C_5
- i_word_valid  in  1  state word valid
- o_word_ready  out  1  state word accepted
- i_word  in  32  state word; column-major order, word k -> x=k/WORDS_PER_COL, y=k%WORDS_PER_COL
- o_word_valid  out  1  output word valid
- i_word_ready  in  1  downstream accepts output word
- o_word  out  32  i_word ^ D[x]
- o_word_last  out  1  high with final (25th) output word
- o_busy  out  1  high in COMPUTE and STREAM

Behaviour:
- Reset (async assert, sync release): state=IDLE; D regs, counters, o_word=0, o_word_valid=0, o_word_last=0, o_busy=0, o_word_ready=0, o_c_ready=1.
- IDLE: o_c_ready=1, o_word_ready=0. On i_c_valid at edge t, latch i_c and go to COMPUTE. i_word_valid is ignored.
- COMPUTE (one cycle, t+1): register D[0..4] from the latched C; clear in-count and out-count; go to STREAM.
- STREAM (from t+2):
  - o_word_ready = (in-count < 25) && (!o_word_valid || i_word_ready).
  - Input handshake at edge e: o_word <= i_word ^ D[x(in-count)], o_word_valid <= 1 at e+1, in-count++.
  - Latency is 1 cycle; full throughput is 1 word per cycle with continuous ready.
  - Output handshake (o_word_valid && i_word_ready): out-count++. o_word_valid clears unless a new word loads on the same edge.
  - Simultaneous accept and load on the same edge is allowed and must not drop or duplicate a word.
  - Under backpressure (i_word_ready=0), o_word and o_word_last hold stable.
  - o_word_last is high while the held word is word index 24.
  - When the 25th word is output-accepted: go to IDLE. o_c_ready=1 on the next cycle.
- i_c_valid outside IDLE: ignored, and the latched C/D values are unchanged.
- Rotation is a pure 32-bit rotate; ROT_AMT=0 gives D[x] = C[x-1] ^ C[x+1].
- Column index wraps mod 5: C[4] (C_5) feeds D[0] and D[3].
- Reset mid-stream: all partial progress is discarded and the output is back at reset values. No word is emitted after reset until a new C is loaded.
- Each input word produces exactly one output word, in order. No reordering, no buffering beyond one entry.

Test Plan:
- C all zero; stream words 0x00000000..0x00000018 with ready held high -> outputs equal inputs; 25 outputs on consecutive cycles; o_word_last only on 0x00000018; o_c_ready=1 one cycle after.
- C[1]=0x00000001, others 0; input words all 0xFFFFFFFF -> column 0 words = 0xFFFFFFFD; column 2 words = 0xFFFFFFFE; columns 1, 3, 4 = 0xFFFFFFFF.
- C[4]=0x80000000, others 0; inputs all 0 -> column 0 = 0x80000000; column 3 = 0x00000001; others 0.
- Backpressure: i_word_ready low for 10 cycles after word 3 loads -> o_word holds word 3 ^ D[0]; o_word_ready=0 while full. After release, all 25 words arrive in order with no loss or duplication.
- Reset asserted after 12 output handshakes -> all outputs go to 0 immediately, o_c_ready=1. A new C load plus 25 words completes correctly.
- i_c_valid pulsed with C[0]=0xDEADBEEF during STREAM -> ignored; outputs still use the original D; o_c_ready stays 0.
